// File: rtl/spart_rx_if.sv
// Bus-side handshake of the SPART receiver: received byte, status flags and read acknowledge.
interface spart_rx_if;
    logic       clr_rda;
    logic [7:0] data;
    logic       rda;
    logic       frame_err;
    logic       overrun;

    modport master (output clr_rda, input data, rda, frame_err, overrun);
    modport slave  (input clr_rda, output data, rda, frame_err, overrun);
endinterface

// File: rtl/spart_rx.sv
// SPART receiver: 8N1 serial input recovered by mid-bit sampling on the shared baud tick,
// held with a data-available flag until the bus side acknowledges it.
module spart_rx #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      RxD,
    spart_rx_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    logic [SYNC_STAGES-1:0] sync_reg, sync_next;
    logic                   rxd_s;

    state_t        state_reg, state_next;
    logic [TW-1:0] tick_reg, tick_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic [7:0]    data_reg, data_next;
    logic          rda_reg, rda_next;
    logic          ferr_reg, ferr_next;
    logic          ovr_reg, ovr_next;
    logic          complete;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = RxD;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign rxd_s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg  <= '1;
            state_reg <= IDLE;
            tick_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            rda_reg   <= 1'b0;
            ferr_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            sync_reg  <= sync_next;
            state_reg <= state_next;
            tick_reg  <= tick_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            rda_reg   <= rda_next;
            ferr_reg  <= ferr_next;
            ovr_reg   <= ovr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        complete   = 1'b0;

        if (en) begin
            case (state_reg)
                IDLE: begin
                    if (!rxd_s) begin
                        state_next = START;
                        tick_next  = '0;
                    end
                end
                START: begin
                    // Mid start bit: a line that has returned high was only a glitch.
                    if (tick_reg == HALF_M1) begin
                        tick_next  = '0;
                        bit_next   = '0;
                        state_next = rxd_s ? IDLE : DATA;
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_reg == FULL_M1) begin
                        tick_next  = '0;
                        shift_next = {rxd_s, shift_reg[7:1]};
                        bit_next   = bit_reg + 1'b1;
                        if (bit_reg == 3'd7) begin
                            state_next = STOP;
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_reg == FULL_M1) begin
                        tick_next  = '0;
                        complete   = 1'b1;
                        state_next = rxd_s ? IDLE : BREAK;
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxd_s) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A completing byte beats a simultaneous acknowledge; the acknowledge still counts as a read.
    always_comb begin
        data_next = data_reg;
        rda_next  = rda_reg;
        ferr_next = ferr_reg;
        ovr_next  = ovr_reg;
        if (complete) begin
            data_next = shift_reg;
            rda_next  = 1'b1;
            ferr_next = !rxd_s;
            if (rda_reg && !bus.clr_rda) begin
                ovr_next = 1'b1;
            end
        end else if (bus.clr_rda) begin
            rda_next = 1'b0;
            ovr_next = 1'b0;
        end
    end

    assign bus.data      = data_reg;
    assign bus.rda       = rda_reg;
    assign bus.frame_err = ferr_reg;
    assign bus.overrun   = ovr_reg;
endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: directed vector table, hand-written corner sequences and
// random frames checked against a byte-level model of the receiver flags.
module tb_spart_rx;
    localparam int OS       = 16;
    localparam int EN_DIV   = 4;
    localparam int COMP_TCK = 152;  // frame tick whose following en edge samples the stop bit

    logic clk, rst, en, rxd;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rise_cnt = 0;
    logic rda_q = 1'b0;

    spart_rx_if bus();

    spart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .en (en),
        .RxD(rxd),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int div;
        div = 0;
        en  = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % EN_DIV;
            en  = (div == 0);
        end
    end

    always @(negedge clk) begin
        if (bus.rda && !rda_q) rise_cnt <= rise_cnt + 1;
        rda_q <= bus.rda;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] d, input logic r,
                           input logic fe, input logic ov);
        @(negedge clk);
        chk($sformatf("%s_data", tag), 32'(bus.data), 32'(d));
        chk($sformatf("%s_rda", tag), 32'(bus.rda), 32'(r));
        chk($sformatf("%s_frame_err", tag), 32'(bus.frame_err), 32'(fe));
        chk($sformatf("%s_overrun", tag), 32'(bus.overrun), 32'(ov));
        $display("txn %s: data=%h rda=%b frame_err=%b overrun=%b", tag, bus.data, bus.rda,
                 bus.frame_err, bus.overrun);
    endtask

    task automatic wait_en(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (en) k++;
        end
        #1;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.clr_rda = 1'b1;
        @(negedge clk);
        bus.clr_rda = 1'b0;
    endtask

    // Drives one 8N1 frame, OS en ticks per bit; optionally a one-clk pulse of clr_rda
    // (or rst) landing exactly on the en edge that ends frame tick pulse_tick.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int pulse_tick,
                              input logic pulse_rst);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        wait_en(1);
        for (int t = 0; t < 10 * OS; t++) begin
            rxd = fr[t / OS];
            if (t == pulse_tick) begin
                repeat (EN_DIV - 1) @(posedge clk);
                @(negedge clk);
                if (pulse_rst) rst = 1'b1; else bus.clr_rda = 1'b1;
                @(posedge clk);
                #1;
                rst         = 1'b0;
                bus.clr_rda = 1'b0;
            end else begin
                wait_en(1);
            end
        end
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         clr_tick;
        logic       clr_after;
        logic [7:0] e_data;
        logic       e_rda;
        logic       e_ferr;
        logic       e_ovr;
        int         e_rise;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int r0;
        logic [7:0] m_data;
        logic m_rda, m_ferr, m_ovr;

        vecs[0] = '{8'hA5, 1'b1, -1,       1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1};
        vecs[1] = '{8'h00, 1'b1, -1,       1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1};
        vecs[2] = '{8'hFF, 1'b1, -1,       1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1};
        vecs[3] = '{8'h3C, 1'b1, -1,       1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1};
        vecs[4] = '{8'h11, 1'b1, -1,       1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1};
        vecs[5] = '{8'h22, 1'b1, -1,       1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 0};
        vecs[6] = '{8'h11, 1'b1, -1,       1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1};
        vecs[7] = '{8'h22, 1'b1, COMP_TCK, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 0};

        rst = 1'b1;
        rxd = 1'b1;
        bus.clr_rda = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            r0 = rise_cnt;
            send_frame(vecs[i].b, vecs[i].stop, vecs[i].clr_tick, 1'b0);
            chk($sformatf("vec%0d_rda_rises", i), 32'(rise_cnt - r0), 32'(vecs[i].e_rise));
            chk_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_rda, vecs[i].e_ferr,
                    vecs[i].e_ovr);
            if (vecs[i].clr_after) begin
                pulse_clr();
                chk_all($sformatf("vec%0d_clr", i), vecs[i].e_data, 1'b0, vecs[i].e_ferr, 1'b0);
            end
        end

        // Frame error followed by a held-low line
        r0 = rise_cnt;
        send_frame(8'h81, 1'b0, -1, 1'b0);
        chk_all("ferr", 8'h81, 1'b1, 1'b1, 1'b0);
        pulse_clr();
        rxd = 1'b0;
        wait_en(40);
        chk("break_rda_rises", 32'(rise_cnt - r0), 32'd1);
        chk_all("break_low", 8'h81, 1'b0, 1'b1, 1'b0);
        rxd = 1'b1;
        wait_en(4);
        send_frame(8'h42, 1'b1, -1, 1'b0);
        chk_all("after_break", 8'h42, 1'b1, 1'b0, 1'b0);
        pulse_clr();

        // False start shorter than half a bit
        r0 = rise_cnt;
        wait_en(1);
        rxd = 1'b0;
        wait_en(3);
        rxd = 1'b1;
        wait_en(20);
        chk("false_start_rises", 32'(rise_cnt - r0), 32'd0);
        chk_all("false_start", 8'h42, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, -1, 1'b0);
        chk_all("after_false_start", 8'h5A, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of data bit 4 (frame ticks 80..95) of 8'hF0
        r0 = rise_cnt;
        send_frame(8'hF0, 1'b1, 88, 1'b1);
        wait_en(4);
        chk("reset_mid_rises", 32'(rise_cnt - r0), 32'd0);
        chk_all("reset_mid", 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1, -1, 1'b0);
        chk_all("after_reset", 8'hC3, 1'b1, 1'b0, 1'b0);

        // Random frames against a byte-level model
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_data = 8'h00; m_rda = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            logic       stop;
            int         pol;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            pol  = int'($urandom_range(0, 2));
            send_frame(b, stop, (pol == 1) ? COMP_TCK : -1, 1'b0);
            m_ovr  = m_ovr | (m_rda & (pol != 1));
            m_rda  = 1'b1;
            m_data = b;
            m_ferr = !stop;
            chk_all($sformatf("rand%0d", i), m_data, m_rda, m_ferr, m_ovr);
            if (pol == 2) begin
                pulse_clr();
                m_rda = 1'b0;
                m_ovr = 1'b0;
                chk_all($sformatf("rand%0d_clr", i), m_data, m_rda, m_ferr, m_ovr);
            end
            rxd = 1'b1;
            wait_en(int'($urandom_range(2, 20)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- UART receive half of the mini SPART. Serial 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
- Sits beside the transmitter and shares the same baud-generator tick `en`, which runs at OVERSAMPLE × the bit rate.
- Recovers each byte by mid-bit sampling. Holds the byte with a received-data-available flag until the bus interface acknowledges it.

Parameters:
- OVERSAMPLE, 16, number of `en` ticks per bit. Must be even and ≥4.
- SYNC_STAGES, 2, depth of the RxD metastability synchronizer. Must be ≥2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  baud tick, one clk wide, OVERSAMPLE per bit period.
- RxD  input  1  asynchronous serial line; idles high.
- clr_rda  input  1  one-cycle pulse: the byte in `data` has been read.
- data  output  8  last received byte.
- rda  output  1  received data available.
- frame_err  output  1  stop bit of the last byte was 0.
- overrun  output  1  a byte completed while rda was still set.

Behaviour:
- Reset (rst high on a clk edge):
  - data=8'h00, rda=0, frame_err=0, overrun=0.
  - State=IDLE; synchronizer flops=1; counters=0.
  - Reset takes priority over everything, including a frame in progress. The partial byte is discarded.
- Synchronizer: RxD passes through SYNC_STAGES flops to give rxd_s. Only rxd_s is used internally.
- All FSM sampling and counting advances only on clk edges where en=1. When en=0, state and counters hold.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - On en with rxd_s=0: go to START, tick counter=0.
  - Otherwise stay in IDLE.
- START:
  - Each en increments the tick counter.
  - On the (OVERSAMPLE/2)th en after the detection tick (mid start bit), sample rxd_s.
  - rxd_s=0: go to DATA, tick counter=0, bit index=0.
  - rxd_s=1: false start; return to IDLE. No flags change.
- DATA:
  - On every OVERSAMPLEth en after the previous sample, shift rxd_s into bit 7 of an 8-bit shift register (right shift, so the first bit received ends in bit 0) and increment the bit index.
  - After the 8th sample, go to STOP with tick counter=0.
- STOP: on the OVERSAMPLEth en, sample the stop bit. On that same clk edge (completion edge):
  - data ← shift register.
  - rda ← 1.
  - frame_err ← (stop sample==0).
  - overrun ← 1 if rda was 1 and clr_rda=0 on that edge; otherwise overrun holds.
  - Next state: IDLE if stop=1, BREAK if stop=0.
- BREAK: stay until an en edge with rxd_s=1, then go to IDLE. This stops a held-low line from re-triggering reception.
- clr_rda:
  - On a non-completion edge: rda←0, overrun←0. frame_err and data hold.
  - If clr_rda coincides with a completion edge, the completion wins: rda=1 and data is the new byte. overrun is not set, because the old byte counts as read.
- clr_rda while rda=0: no effect.
- Latency:
  - The sampling point is (OVERSAMPLE/2 + 9·OVERSAMPLE) en ticks after the start-detect tick.
  - The completion edge is that tick's clk edge.
  - The registered rda/data are visible on the next cycle.
- Tolerance: because sampling is mid-bit, the receiver accepts baud mismatch up to ±(OVERSAMPLE/2−1)/(10·OVERSAMPLE) of the bit period, accumulated over the frame.
- Outputs are registered; no combinational path exists from RxD to any output.

Test Plan:
- Nominal byte: en every 4 clk (bit=64 clk). Drive 8'hA5 8N1.
  - Expect rda rising once, data=8'hA5, frame_err=0, overrun=0.
  - Then pulse clr_rda: rda=0 next cycle, data still 8'hA5.
- Back-to-back bytes: drive 8'h00, 8'hFF, 8'h3C with no idle gap, clr_rda after each.
  - Expect three completions with the correct data and no frame_err.
- False start: drive RxD low for 3 en ticks (<OVERSAMPLE/2), then high.
  - Expect FSM back in IDLE, rda=0, all flags 0.
  - A following 8'h5A is received correctly.
- Frame error and break: drive 8'h81 with stop=0, hold RxD low for 40 en ticks, then high, then send 8'h42.
  - Expect frame_err=1 with data=8'h81 and no spurious second byte during the low period.
  - Then data=8'h42 with frame_err=0.
- Overrun: receive 8'h11, no clr_rda, receive 8'h22.
  - Expect data=8'h22, rda=1, overrun=1.
  - clr_rda then clears rda and overrun.
  - Repeat with clr_rda asserted exactly on the 8'h22 completion edge: expect overrun stays 0 and rda=1.
- Reset mid-frame: assert rst for one cycle during bit 4 of 8'hF0.
  - Expect data=8'h00 and all flags 0. No byte from the aborted frame.
  - A subsequent 8'hC3 is received correctly.
